hamming_decoder_pipe: RTL
=========================

Name: hamming_decoder_pipe

Overview:
- Receive-side counterpart of the team's 7-bit Hamming encoder. Accepts 7-bit codewords over a valid/ready stream and returns the recovered 4-bit data word.
- Computes a 3-bit syndrome, corrects every uniquely identifiable single-bit error, and flags ambiguous or invalid syndromes as uncorrectable.
- Two-stage pipeline with full backpressure and saturating error-statistics counters. Sits between the channel/link input and the data consumer.

Parameters:
- CNT_W, 16, width of each saturating error counter (≥2).

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  reset, asynchronous, active-high
- in_valid  input  1  code holds a valid codeword
- in_ready  output  1  block accepts code this cycle
- code  input  7  codeword, bit layout identical to encoder output
- out_valid  output  1  data/flags valid
- out_ready  input  1  consumer accepts output
- data  output  4  decoded (corrected) data
- syndrome  output  3  {s1,s2,s3} of the word on data
- err_corrected  output  1  single-bit error found and fixed
- err_uncorrectable  output  1  syndrome 111 or 011; data is uncorrected raw data
- cnt_clear  input  1  synchronous clear of both counters
- corr_count  output  CNT_W  number of accepted outputs with err_corrected
- uncorr_count  output  CNT_W  number of accepted outputs with err_uncorrectable

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-high, ports named clk and rst.
- Reset values: out_valid=0, data=0, syndrome=0, both flags 0, both counters 0, internal stage valids 0. in_ready=0 while rst=1.
- Codeword layout:
  - c6=p1, c5=p2, c4=d0, c3=p3, c2=d1, c1=d2, c0=d3.
  - Raw data = {c0,c1,c2,c4} mapped to data[3:0].
- Syndrome:
  - s1=c6^c4^c2^c1^c0
  - s2=c5^c4^c2^c1
  - s3=c3^c4^c2^c0
- Syndrome decode:
  - 000: clean, no flags.
  - 100 / 010 / 001: parity bit c6 / c5 / c3 in error. data = raw data, err_corrected=1.
  - 110: flip c1 (data[2]), err_corrected=1.
  - 101: flip c0 (data[3]), err_corrected=1.
  - 111: c4 or c2 ambiguous (d0, d1 share a syndrome). No correction, err_uncorrectable=1.
  - 011: no single-bit cause. No correction, err_uncorrectable=1.
- Pipeline:
  - Stage 1 registers code and syndrome on in_valid&in_ready.
  - Stage 2 registers data, syndrome and flags.
  - Latency: accepted at edge N, visible on outputs after edge N+1 (out_valid high in cycle N+2 relative to acceptance cycle N), with out_ready held high.
- Handshake:
  - s1_adv = !s2_valid || out_ready; in_ready = !s1_valid || s1_adv.
  - Throughput is 1 word/cycle when out_ready=1.
  - out_valid and all outputs stay stable while out_valid&!out_ready; no word lost or duplicated.
  - in_ready may depend combinationally on out_ready; no combinational path from in_valid to in_ready.
- Counters:
  - Increment on out_valid&out_ready when the corresponding flag is set.
  - Saturate at all-ones, no wrap.
  - cnt_clear has priority over a same-cycle increment: result is 0.
- Reset mid-operation: in-flight words discarded, outputs return to reset values asynchronously.
- Known limitation (by design): double-bit errors may be miscorrected or reported as uncorrectable; no detection guarantee.

Test Plan:
- Clean word: code=7'h5D (data 4'hB) with out_ready=1 → 2 cycles later out_valid=1, data=4'hB, syndrome=000, both flags 0.
- Correctable data error: code=7'h5F (c1 flipped) → data=4'hB, syndrome=110, err_corrected=1, corr_count increments by 1. Also code=7'h1D (c6 flipped) → data=4'hB, syndrome=100, err_corrected=1.
- Ambiguous error: code=7'h4D (c4 flipped) → syndrome=111, err_uncorrectable=1, data=4'hA (raw), uncorr_count increments by 1.
- Backpressure: stream 5 words back-to-back with out_ready low for 4 cycles mid-stream → in_ready drops once both stages are full, outputs stay stable, all 5 words exit in order with no loss.
- Counters: CNT_W=2, send 5 corrected words → corr_count saturates at 3. Assert cnt_clear in the same cycle as an accepted corrected word → counter reads 0.
- Reset mid-stream: assert rst while both stages are valid → out_valid=0 and counters 0 immediately. After release, the first new word decodes correctly with 2-cycle latency.

Source files
------------

// File: rtl/hamming_decoder_pipe.sv
// Two-stage Hamming(7,4) receive decoder with valid/ready backpressure and
// saturating corrected/uncorrectable error counters.
module hamming_decoder_pipe #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [6:0]       code,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       data,
  output logic [2:0]       syndrome,
  output logic             err_corrected,
  output logic             err_uncorrectable,
  input  logic             cnt_clear,
  output logic [CNT_W-1:0] corr_count,
  output logic [CNT_W-1:0] uncorr_count
);

  logic             r_s1_valid;
  logic [6:0]       r_s1_code;
  logic [2:0]       r_s1_syn;
  logic             r_s2_valid;
  logic [3:0]       r_data;
  logic [2:0]       r_syn;
  logic             r_corr;
  logic             r_uncorr;
  logic [CNT_W-1:0] r_corr_count;
  logic [CNT_W-1:0] r_uncorr_count;

  logic [2:0] w_syn;
  logic       w_s1_adv;
  logic       w_in_ready;
  logic       w_accept;
  logic [3:0] w_dec_data;
  logic       w_dec_corr;
  logic       w_dec_uncorr;

  // Syndrome is {s1,s2,s3}; c6..c0 = p1,p2,d0,p3,d1,d2,d3.
  assign w_syn[2] = code[6] ^ code[4] ^ code[2] ^ code[1] ^ code[0];
  assign w_syn[1] = code[5] ^ code[4] ^ code[2] ^ code[1];
  assign w_syn[0] = code[3] ^ code[4] ^ code[2] ^ code[0];

  assign w_s1_adv   = !r_s2_valid || out_ready;
  assign w_in_ready = !rst && (!r_s1_valid || w_s1_adv);
  assign w_accept   = r_s2_valid && out_ready;

  // NOTE: every output of an always_comb is defaulted first so no path can infer a latch.
  always_comb begin
    w_dec_data   = {r_s1_code[0], r_s1_code[1], r_s1_code[2], r_s1_code[4]};
    w_dec_corr   = 1'b0;
    w_dec_uncorr = 1'b0;
    case (r_s1_syn)
      3'b100, 3'b010, 3'b001: w_dec_corr = 1'b1;
      3'b110: begin
        w_dec_data[2] = ~w_dec_data[2];
        w_dec_corr    = 1'b1;
      end
      3'b101: begin
        w_dec_data[3] = ~w_dec_data[3];
        w_dec_corr    = 1'b1;
      end
      3'b111, 3'b011: w_dec_uncorr = 1'b1;
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_code  <= '0;
      r_s1_syn   <= '0;
    end else if (w_in_ready) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_code <= code;
        r_s1_syn  <= w_syn;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s2_valid <= 1'b0;
      r_data     <= '0;
      r_syn      <= '0;
      r_corr     <= 1'b0;
      r_uncorr   <= 1'b0;
    end else if (w_s1_adv) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_data   <= w_dec_data;
        r_syn    <= r_s1_syn;
        r_corr   <= w_dec_corr;
        r_uncorr <= w_dec_uncorr;
      end
    end
  end

  // Clear wins over a same-cycle increment; counts stick at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_corr_count   <= '0;
      r_uncorr_count <= '0;
    end else if (cnt_clear) begin
      r_corr_count   <= '0;
      r_uncorr_count <= '0;
    end else if (w_accept) begin
      if (r_corr && (r_corr_count != '1))
        r_corr_count <= r_corr_count + 1'b1;
      if (r_uncorr && (r_uncorr_count != '1))
        r_uncorr_count <= r_uncorr_count + 1'b1;
    end
  end

  assign in_ready          = w_in_ready;
  assign out_valid         = r_s2_valid;
  assign data              = r_data;
  assign syndrome          = r_syn;
  assign err_corrected     = r_corr;
  assign err_uncorrectable = r_uncorr;
  assign corr_count        = r_corr_count;
  assign uncorr_count      = r_uncorr_count;

endmodule
